// File: rtl/dark_rst_seq.sv
// dark_rst_seq: SoC reset sequencer.
//
// Releases the peripheral reset first and the core reset after it. This
// happens after an external reset and after a software reset. A software
// reset first waits for the bus to go idle (or for a drain timeout). It then
// holds both resets for a minimum time before the release sequence runs again.
//
// Parameters
//   PERIPH_HOLD  cycles PERIPH_RES stays high once the release sequence starts
//   CORE_HOLD    cycles from PERIPH_RES release to CORE_RES release
//   ASSERT_HOLD  minimum cycles both resets are held during a software reset
//   DRAIN_MAX    maximum cycles spent waiting for BUSY to drop
//   A value of 0 for any of these is treated as 1.
//
// Ports
//   XCLK        in   clock, rising edge
//   XRES        in   synchronous active-high reset
//   SWRST_REQ   in   software reset request pulse (honoured only in RUN)
//   BUSY        in   bus transaction in flight (looked at only in DRAIN)
//   CORE_RES    out  core reset, active-high, registered
//   PERIPH_RES  out  peripheral reset, active-high, registered
//   RDY         out  high exactly while in RUN, registered
//   RST_CAUSE   out  01 external, 10 software, 11 software after drain timeout
//   RST_COUNT   out  completed software resets, saturating at 255
module dark_rst_seq #(
    parameter int unsigned PERIPH_HOLD = 2,
    parameter int unsigned CORE_HOLD   = 4,
    parameter int unsigned ASSERT_HOLD = 3,
    parameter int unsigned DRAIN_MAX   = 16
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic       SWRST_REQ,
    input  logic       BUSY,
    output logic       CORE_RES,
    output logic       PERIPH_RES,
    output logic       RDY,
    output logic [1:0] RST_CAUSE,
    output logic [7:0] RST_COUNT
);

    // Clamp every hold time to at least one cycle.
    localparam int unsigned PHold = (PERIPH_HOLD == 0) ? 1 : PERIPH_HOLD;
    localparam int unsigned CHold = (CORE_HOLD == 0)   ? 1 : CORE_HOLD;
    localparam int unsigned AHold = (ASSERT_HOLD == 0) ? 1 : ASSERT_HOLD;
    localparam int unsigned DMax  = (DRAIN_MAX == 0)   ? 1 : DRAIN_MAX;

    localparam int unsigned MaxPc   = (PHold > CHold) ? PHold : CHold;
    localparam int unsigned MaxAd   = (AHold > DMax) ? AHold : DMax;
    localparam int unsigned MaxHold = (MaxPc > MaxAd) ? MaxPc : MaxAd;
    // The counter only ever reaches MaxHold-1.
    localparam int unsigned CntW    = (MaxHold <= 1) ? 1 : $clog2(MaxHold);

    localparam logic [CntW-1:0] PLast = CntW'(PHold - 1);
    localparam logic [CntW-1:0] CLast = CntW'(CHold - 1);
    localparam logic [CntW-1:0] ALast = CntW'(AHold - 1);
    localparam logic [CntW-1:0] DLast = CntW'(DMax - 1);

    typedef enum logic [2:0] {
        StHold,
        StRelPeriph,
        StRelCore,
        StRun,
        StDrain,
        StAssert
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic            core_res_q, core_res_d;
    logic            periph_res_q, periph_res_d;
    logic            rdy_q, rdy_d;

    // State and output registers. An external reset also clears the
    // software reset count, so an aborted software reset never counts.
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            cause_q      <= 2'b01;
            count_q      <= 8'd0;
            core_res_q   <= 1'b1;
            periph_res_q <= 1'b1;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
            core_res_q   <= core_res_d;
            periph_res_q <= periph_res_d;
            rdy_q        <= rdy_d;
        end
    end

    // Next-state logic. The hold counter restarts at 0 on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            StHold: begin
                state_d = StRelPeriph;
                cnt_d   = '0;
            end
            StRelPeriph: begin
                if (cnt_q == PLast) begin
                    state_d = StRelCore;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelCore: begin
                if (cnt_q == CLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (SWRST_REQ) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // An idle bus wins over a timeout in the same cycle.
                if (!BUSY) begin
                    state_d = StAssert;
                    cause_d = 2'b10;
                    cnt_d   = '0;
                end else if (cnt_q == DLast) begin
                    state_d = StAssert;
                    cause_d = 2'b11;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAssert: begin
                if (cnt_q == ALast) begin
                    state_d = StRelPeriph;
                    cnt_d   = '0;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they are registered and change
    // on the same edge as the state they belong to.
    always_comb begin
        core_res_d   = 1'b0;
        periph_res_d = 1'b0;
        rdy_d        = 1'b0;
        unique case (state_d)
            StHold, StRelPeriph, StAssert: begin
                core_res_d   = 1'b1;
                periph_res_d = 1'b1;
            end
            StRelCore: core_res_d = 1'b1;
            StRun:     rdy_d      = 1'b1;
            default:   ;
        endcase
    end

    assign CORE_RES   = core_res_q;
    assign PERIPH_RES = periph_res_q;
    assign RDY        = rdy_q;
    assign RST_CAUSE  = cause_q;
    assign RST_COUNT  = count_q;

endmodule

// File: tb/tb_dark_rst_seq.sv
// Scoreboard bench for dark_rst_seq. Stimulus pushes every expected output
// change, with the cycle it must appear on, into a queue. The monitor pops an
// entry whenever the sampled output vector changes and compares both.
module tb_dark_rst_seq;

    logic       clk = 1'b0;
    logic       xres, swrst_req, busy;
    logic       core_res, periph_res, rdy;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [12:0] v;
    } exp_t;

    exp_t q[$];

    // Bench model of the reset cause and software reset count.
    logic [1:0] cause_e;
    logic [7:0] n_e;

    dark_rst_seq dut (
        .XCLK      (clk),
        .XRES      (xres),
        .SWRST_REQ (swrst_req),
        .BUSY      (busy),
        .CORE_RES  (core_res),
        .PERIPH_RES(periph_res),
        .RDY       (rdy),
        .RST_CAUSE (rst_cause),
        .RST_COUNT (rst_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] vec(input bit c, input bit p, input bit r,
                                        input logic [1:0] cs, input logic [7:0] n);
        return {c, p, r, cs, n};
    endfunction

    task automatic push(input int c, input logic [12:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    // XRES was just dropped after the edge at cycle r: expect the release sequence.
    task automatic push_release(input int r);
        push(r + 3, vec(1, 0, 0, cause_e, n_e));
        push(r + 7, vec(0, 0, 1, cause_e, n_e));
    endtask

    // Software reset from RUN. BUSY is held for busy_cycles drain cycles,
    // or forever when timeout is set.
    task automatic sw_reset(input int busy_cycles, input bit timeout);
        int t;
        int a;
        logic [7:0] n_new;
        t = cyc;
        swrst_req = 1'b1;
        busy = (busy_cycles > 0) || timeout;
        push(t + 1, vec(0, 0, 0, cause_e, n_e));
        a = timeout ? t + 17 : t + 2 + busy_cycles;
        cause_e = timeout ? 2'b11 : 2'b10;
        push(a, vec(1, 1, 0, cause_e, n_e));
        n_new = (n_e == 8'hFF) ? 8'hFF : n_e + 8'd1;
        if (n_new != n_e) push(a + 3, vec(1, 1, 0, cause_e, n_new));
        n_e = n_new;
        push(a + 5, vec(1, 0, 0, cause_e, n_e));
        push(a + 9, vec(0, 0, 1, cause_e, n_e));
        tick();
        swrst_req = 1'b0;
        if (busy) begin
            wait_to(timeout ? a : a - 1);
            busy = 1'b0;
        end
        wait_to(a + 10);
    endtask

    // Monitor: one comparison per output change.
    logic [12:0] prev = 'x;
    always @(negedge clk) begin
        logic [12:0] cur;
        exp_t e;
        cur = {core_res, periph_res, rdy, rst_cause, rst_count};
        if (cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h prev=%h required=no change",
                         cyc, cur, prev);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    errors++;
                    $display("FAIL output_change got=%h at cyc %0d required=%h at cyc %0d",
                             cur, cyc, e.v, e.cyc);
                end
            end
            prev = cur;
        end
    end

    initial begin
        int t;
        xres = 1'b1;
        swrst_req = 1'b0;
        busy = 1'b0;
        cause_e = 2'b01;
        n_e = 8'd0;

        // Power-on reset: XRES high for two edges.
        push(1, vec(1, 1, 0, 2'b01, 8'd0));
        tick();
        tick();
        xres = 1'b0;
        push_release(cyc);

        // Request during REL_CORE is ignored; BUSY in RUN is ignored.
        wait_to(5);
        swrst_req = 1'b1;
        tick();
        swrst_req = 1'b0;
        wait_to(10);
        busy = 1'b1;
        tick();
        busy = 1'b0;

        // XRES pulse in the middle of DRAIN aborts the software reset.
        wait_to(13);
        t = cyc;
        swrst_req = 1'b1;
        busy = 1'b1;
        push(t + 1, vec(0, 0, 0, 2'b01, 8'd0));
        tick();
        swrst_req = 1'b0;
        wait_to(t + 3);
        xres = 1'b1;
        push(t + 4, vec(1, 1, 0, 2'b01, 8'd0));
        tick();
        xres = 1'b0;
        busy = 1'b0;
        push_release(cyc);
        wait_to(t + 13);

        sw_reset(0, 1'b0);    // idle bus
        sw_reset(5, 1'b0);    // drain wait
        sw_reset(0, 1'b1);    // drain timeout
        sw_reset(15, 1'b0);   // bus idles on the timeout cycle
        for (int i = 0; i < 253; i++) sw_reset(0, 1'b0);  // saturation

        // External reset clears cause and count.
        t = cyc;
        xres = 1'b1;
        cause_e = 2'b01;
        n_e = 8'd0;
        push(t + 1, vec(1, 1, 0, 2'b01, 8'd0));
        tick();
        xres = 1'b0;
        push_release(cyc);
        wait_to(t + 12);

        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change got=none required=%h at cyc %0d", e.v, e.cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
